// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Brief    : Multi-port integer register file with optional write-to-read
//             bypass, per-register busy scoreboard and busy counter.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [AW:0]         busy_cnt,
  output logic                any_busy
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busy_cnt;

  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW:0]      w_inc;
  logic [AW:0]      w_dec;

  // Storage update; later ports overwrite earlier ones so the highest index wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != '0))
          r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  // Per-register set/clear requests; several writes to one address collapse to one clear
  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int r = 1; r < NREGS; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) w_clr[r] = 1'b1;
      end
      if (iss_en && (iss_addr == AW'(r))) w_set[r] = 1'b1;
    end
  end

  // Next busy vector and counter deltas; an issue supersedes a same-cycle write
  always_comb begin
    w_busy_nxt = r_busy;
    w_inc      = '0;
    w_dec      = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (w_set[r]) begin
        w_busy_nxt[r] = 1'b1;
        if (!r_busy[r]) w_inc = w_inc + (AW+1)'(1);
      end else if (w_clr[r]) begin
        w_busy_nxt[r] = 1'b0;
        if (r_busy[r]) w_dec = w_dec + (AW+1)'(1);
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard and incrementally maintained popcount
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= r_busy_cnt + w_inc - w_dec;
    end
  end

  assign busy_cnt = r_busy_cnt;
  assign any_busy = (r_busy_cnt != '0);

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_val;

      assign w_addr = rd_addr[k*AW +: AW];

      // Stored value, optionally overridden by the highest-index matching write
      always_comb begin
        w_val = r_regs[w_addr];
        if ((BYPASS != 0) && (w_addr != '0)) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == w_addr))
              w_val = wr_data[j*XLEN +: XLEN];
          end
        end
      end

      assign rd_data[k*XLEN +: XLEN] = w_val;
      assign rd_busy[k]              = r_busy[w_addr];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Brief    : Directed self-checking bench for regfile_mp (bypass and
//             non-bypass instances driven by shared stimulus).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;

  logic [NRD*XLEN-1:0] rd_data_b,  rd_data_n;
  logic [NRD-1:0]      rd_busy_b,  rd_busy_n;
  logic [AW:0]         busy_cnt_b, busy_cnt_n;
  logic                any_busy_b, any_busy_n;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .busy_cnt(busy_cnt_b), .any_busy(any_busy_b)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .busy_cnt(busy_cnt_n), .any_busy(any_busy_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[port]               = 1'b1;
    wr_addr[port*AW +: AW]    = a;
    wr_data[port*XLEN +: XLEN] = d;
  endtask

  task automatic iss(input logic [AW-1:0] a);
    iss_en   = 1'b1;
    iss_addr = a;
  endtask

  task automatic rd(input int port, input logic [AW-1:0] a);
    rd_addr[port*AW +: AW] = a;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    rd(0, 5'd5); #1;
    check("rst_rd0",  rd_data_b[31:0], 0);
    check("rst_cnt",  busy_cnt_b, 0);
    check("rst_any",  any_busy_b, 0);

    // Write x5 and issue x6, then asynchronous reset mid-cycle
    wr(0, 5'd5, 32'hDEADBEEF); iss(5'd6);
    tick(); idle(); #1;
    check("pre_rst_x5",  rd_data_n[31:0], 32'hDEADBEEF);
    check("pre_rst_cnt", busy_cnt_b, 1);
    #2 rst = 1'b1; #1;
    check("arst_x5",  rd_data_b[31:0], 0);
    check("arst_cnt", busy_cnt_b, 0);
    check("arst_any", any_busy_b, 0);
    #1 rst = 1'b0;
    tick();

    // Bypass vs. stored read of x7
    wr(0, 5'd7, 32'h12345678); rd(0, 5'd7); #1;
    check("byp_same",   rd_data_b[31:0], 32'h12345678);
    check("nobyp_same", rd_data_n[31:0], 0);
    tick(); idle(); #1;
    check("nobyp_next", rd_data_n[31:0], 32'h12345678);

    // Write collision on x3: highest port wins
    wr(0, 5'd3, 32'h1111); wr(1, 5'd3, 32'h2222); rd(1, 5'd3); #1;
    check("coll_byp", rd_data_b[63:32], 32'h2222);
    tick(); idle(); #1;
    check("coll_st_b", rd_data_b[63:32], 32'h2222);
    check("coll_st_n", rd_data_n[63:32], 32'h2222);

    // x0 stays zero and never busy
    wr(0, 5'd0, 32'hFFFFFFFF); iss(5'd0); rd(0, 5'd0); #1;
    check("x0_byp", rd_data_b[31:0], 0);
    tick(); idle(); #1;
    check("x0_rd",   rd_data_b[31:0], 0);
    check("x0_busy", rd_busy_b[0], 0);
    check("x0_cnt",  busy_cnt_b, 0);

    // Scoreboard on x4
    iss(5'd4); rd(0, 5'd4); #1;
    check("sb_not_early", rd_busy_b[0], 0);
    tick(); idle(); #1;
    check("sb_busy", rd_busy_b[0], 1);
    check("sb_cnt1", busy_cnt_b, 1);
    check("sb_any1", any_busy_b, 1);
    iss(5'd4); wr(0, 5'd4, 32'hA);
    tick(); idle(); #1;
    check("sb_iss_wins", rd_busy_b[0], 1);
    check("sb_cnt_keep", busy_cnt_b, 1);
    wr(0, 5'd4, 32'hB); #1;
    check("sb_no_bypass", rd_busy_b[0], 1);
    tick(); idle(); #1;
    check("sb_clear",   rd_busy_b[0], 0);
    check("sb_cnt0",    busy_cnt_b, 0);
    check("sb_any0",    any_busy_b, 0);
    check("sb_data",    rd_data_n[31:0], 32'hB);

    // Counter: fill x1..x31
    for (int r = 1; r < NREGS; r++) begin
      iss(AW'(r));
      tick();
    end
    idle(); #1;
    check("cnt_full", busy_cnt_b, 31);
    iss(5'd5);
    tick(); idle(); #1;
    check("cnt_reiss", busy_cnt_b, 31);
    wr(0, 5'd1, 32'h1); wr(1, 5'd2, 32'h2);
    tick(); idle(); #1;
    check("cnt_dual", busy_cnt_b, 29);
    wr(0, 5'd3, 32'h3); wr(1, 5'd3, 32'h33);
    tick(); idle(); #1;
    check("cnt_same",  busy_cnt_b, 28);
    check("cnt_same_n", busy_cnt_n, 28);
    wr(0, 5'd1, 32'h7);
    tick(); idle(); #1;
    check("cnt_nonbusy_wr", busy_cnt_b, 28);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
